// File: rtl/inst_rom_if.sv
// Fetch and program-load signal bundle for inst_rom.
// master = CPU / loader side, slave = the ROM responder.
interface inst_rom_if #(
   parameter int ADDR_W = 10
);
   logic [31:0]     addr_rom_i;
   logic [31:0]     data_rom_o;
   logic            rom_valid_o;
   logic            addr_err_o;
   logic            load_en_i;
   logic            load_byte_valid_i;
   logic [7:0]      load_byte_i;
   logic            cpu_hold_o;
   logic            load_done_o;
   logic            load_overflow_o;
   logic [ADDR_W:0] load_count_o;

   modport master (
      output addr_rom_i, load_en_i, load_byte_valid_i, load_byte_i,
      input  data_rom_o, rom_valid_o, addr_err_o, cpu_hold_o,
             load_done_o, load_overflow_o, load_count_o
   );

   modport slave (
      input  addr_rom_i, load_en_i, load_byte_valid_i, load_byte_i,
      output data_rom_o, rom_valid_o, addr_err_o, cpu_hold_o,
             load_done_o, load_overflow_o, load_count_o
   );
endinterface

// File: rtl/inst_rom.sv
// Instruction ROM responder: 1-cycle registered fetch port plus a
// byte-serial little-endian program loader that holds the CPU off.
module inst_rom #(
   parameter int ADDR_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   inst_rom_if.slave  rom
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_PTR = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [31:0]       asm_q, asm_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       data_q;
   logic              valid_q, err_q, hold_q, done_q;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              full;
   logic              fetch_err;
   logic              serve;
   logic [ADDR_W-1:0] ridx;

   logic [31:0]       mem [DEPTH];

   assign full      = (wptr_q == FULL_PTR);
   assign fetch_err = (|rom.addr_rom_i[1:0]) || (|rom.addr_rom_i[31:ADDR_W+2]);
   assign ridx      = rom.addr_rom_i[ADDR_W+1:2];
   // Fetches are served only while staying in RUN, so the entry cycle into LOAD already reads as idle.
   assign serve     = (state_q == S_RUN) && (state_d == S_RUN);

   // Load sequencing: byte assembly, word commit and next state.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      we      = 1'b0;
      waddr   = wptr_q[ADDR_W-1:0];
      wdata   = asm_q;
      case (state_q)
         S_RUN: begin
            if (rom.load_en_i) begin
               state_d = S_LOAD;
               bcnt_d  = '0;
               asm_d   = '0;
               wptr_d  = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (!rom.load_en_i) state_d = S_FLUSH;
            if (rom.load_byte_valid_i) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else if (bcnt_q == 2'd3) begin
                  we     = 1'b1;
                  wdata  = {rom.load_byte_i, asm_q[23:0]};
                  wptr_d = wptr_q + ONE;
                  cnt_d  = cnt_q + ONE;
                  bcnt_d = '0;
                  asm_d  = '0;
               end else begin
                  case (bcnt_q)
                     2'd0:    asm_d[7:0]   = rom.load_byte_i;
                     2'd1:    asm_d[15:8]  = rom.load_byte_i;
                     default: asm_d[23:16] = rom.load_byte_i;
                  endcase
                  bcnt_d = bcnt_q + 2'd1;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_RUN;
            // A pending partial word can only exist below a full array; upper bytes are already zero.
            if (bcnt_q != 2'd0) begin
               we     = 1'b1;
               wptr_d = wptr_q + ONE;
               cnt_d  = cnt_q + ONE;
               bcnt_d = '0;
               asm_d  = '0;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // Control, loader and fetch-response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         bcnt_q  <= '0;
         asm_q   <= '0;
         wptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         hold_q  <= (state_d != S_RUN);
         done_q  <= (state_d == S_FLUSH);
         valid_q <= serve;
         err_q   <= serve && fetch_err;
         if (serve && !fetch_err) data_q <= mem[ridx];
         else                     data_q <= '0;
      end
   end

   // Array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rom.data_rom_o      = data_q;
   assign rom.rom_valid_o     = valid_q;
   assign rom.addr_err_o      = err_q;
   assign rom.cpu_hold_o      = hold_q;
   assign rom.load_done_o     = done_q;
   assign rom.load_overflow_o = ovf_q;
   assign rom.load_count_o    = cnt_q;
endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: random loads and fetches against a
// word-packing reference model.
module tb_inst_rom;
   localparam int AW    = 10;
   localparam int DEPTH = 2 ** AW;

   logic clk = 1'b0;
   logic rst;

   inst_rom_if #(.ADDR_W(AW)) bus ();

   inst_rom #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .rom (bus)
   );

   always #5 clk = ~clk;

   int vectors   = 0;
   int miscomp   = 0;
   logic [32:0] sbq [$];
   logic [31:0] ref_mem [DEPTH];
   int hi_water = 0;
   int exp_cnt  = 0;
   bit exp_ovf  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscomp++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bytes pack little-endian 4 per word from word 0; the last partial
   // word is zero-padded only when the load completes normally.
   task automatic model_load(input logic [7:0] b[$], input bit commit);
      int n;
      int words;
      logic [31:0] w;
      n = b.size();
      words = commit ? (n + 3) / 4 : n / 4;
      if (words > DEPTH) words = DEPTH;
      for (int i = 0; i < words; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++)
            if (4 * i + k < n) w = w | (32'(b[4 * i + k]) << (8 * k));
         ref_mem[i] = w;
      end
      exp_cnt = commit ? words : 0;
      exp_ovf = commit && (n > 4 * DEPTH);
      if (words > hi_water) hi_water = words;
   endtask

   task automatic chk_loading();
      chk("hold_in_load", 64'(bus.cpu_hold_o), 64'd1);
      chk("valid_in_load", 64'(bus.rom_valid_o), 64'd0);
      chk("data_in_load", 64'(bus.data_rom_o), 64'd0);
      chk("done_early", 64'(bus.load_done_o), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"}, 64'(bus.data_rom_o), 64'd0);
      chk({tag, "_valid"}, 64'(bus.rom_valid_o), 64'd0);
      chk({tag, "_err"}, 64'(bus.addr_err_o), 64'd0);
      chk({tag, "_hold"}, 64'(bus.cpu_hold_o), 64'd0);
      chk({tag, "_done"}, 64'(bus.load_done_o), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.load_overflow_o), 64'd0);
      chk({tag, "_count"}, 64'(bus.load_count_o), 64'd0);
   endtask

   task automatic do_load(input logic [7:0] b[$], input bit fall_last, input int max_gap, input bit abort);
      int gaps;
      @(negedge clk);
      bus.load_en_i         = 1'b1;
      bus.load_byte_valid_i = 1'b1;
      bus.load_byte_i       = 8'hEE;   // presented in RUN: must be ignored
      for (int i = 0; i < b.size(); i++) begin
         gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gaps) begin
            @(negedge clk);
            chk_loading();
            bus.load_byte_valid_i = 1'b0;
         end
         @(negedge clk);
         chk_loading();
         bus.load_byte_valid_i = 1'b1;
         bus.load_byte_i       = b[i];
         if (fall_last && i == b.size() - 1) bus.load_en_i = 1'b0;
      end
      if (abort) begin
         @(negedge clk);
         #2;
         rst = 1'b1;
         bus.load_en_i         = 1'b0;
         bus.load_byte_valid_i = 1'b0;
         #1;
         chk_reset_outputs("abort");
         @(negedge clk);
         rst = 1'b0;
         model_load(b, 1'b0);
         return;
      end
      if (!fall_last) begin
         @(negedge clk);
         chk_loading();
         bus.load_byte_valid_i = 1'b0;
         bus.load_en_i         = 1'b0;
      end
      @(negedge clk);
      bus.load_byte_valid_i = 1'b0;
      chk("done_pulse", 64'(bus.load_done_o), 64'd1);
      chk("hold_flush", 64'(bus.cpu_hold_o), 64'd1);
      chk("valid_flush", 64'(bus.rom_valid_o), 64'd0);
      @(negedge clk);
      model_load(b, 1'b1);
      chk("done_clear", 64'(bus.load_done_o), 64'd0);
      chk("hold_clear", 64'(bus.cpu_hold_o), 64'd0);
      chk("load_count", 64'(bus.load_count_o), 64'(exp_cnt));
      chk("overflow", 64'(bus.load_overflow_o), 64'(exp_ovf));
   endtask

   task automatic fetch(input logic [31:0] a);
      logic err;
      logic [31:0] d;
      @(negedge clk);
      bus.addr_rom_i = a;
      err = (a % 4 != 0) || (a / 4 >= DEPTH);
      d = err ? 32'd0 : ref_mem[a / 4];
      sbq.push_back({err, d});
   endtask

   task automatic drain();
      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", 64'(sbq.size()), 64'd0);
      sbq.delete();
   endtask

   task automatic rand_fetch(input int n);
      logic [31:0] a;
      int r;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6 && hi_water > 0) begin
            a = 32'($urandom_range(0, hi_water - 1)) << 2;
         end else if (r < 8) begin
            a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
         end else begin
            a = $urandom;
            if (a < 32'(4 * DEPTH)) a = a | 32'h8000_0000;
         end
         fetch(a);
      end
      drain();
   endtask

   task automatic rand_bytes(input int n, output logic [7:0] b[$]);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b[$];
      logic [32:0] e;
      rst                   = 1'b1;
      bus.addr_rom_i        = '0;
      bus.load_en_i         = 1'b0;
      bus.load_byte_valid_i = 1'b0;
      bus.load_byte_i       = '0;

      fork
         forever begin
            @(posedge clk);
            #1;
            if (bus.rom_valid_o && sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("fetch_data", 64'(bus.data_rom_o), 64'(e[31:0]));
               chk("fetch_err", 64'(bus.addr_err_o), 64'(e[32]));
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
      do_load(b, 1'b0, 0, 1'b0);
      fetch(32'h0); fetch(32'h4); fetch(32'h0);
      drain();
      fetch(32'h2); fetch(32'(1) << (AW + 2));
      drain();

      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      do_load(b, 1'b0, 1, 1'b0);
      fetch(32'h4); fetch(32'h0);
      drain();

      rand_bytes(4, b);
      do_load(b, 1'b1, 0, 1'b0);
      fetch(32'h0); fetch(32'h4);
      drain();

      rand_bytes(7, b);
      do_load(b, 1'b1, 2, 1'b0);
      fetch(32'h4); fetch(32'h0);
      drain();

      for (int t = 0; t < 4; t++) begin
         rand_bytes(int'($urandom_range(1, 40)), b);
         do_load(b, 1'($urandom), 3, 1'b0);
         rand_fetch(40);
      end

      rand_bytes(DEPTH * 4 + 4, b);
      do_load(b, 1'b0, 0, 1'b0);
      rand_fetch(300);

      rand_bytes(5, b);
      do_load(b, 1'b0, 0, 1'b0);
      fetch(32'h4); fetch(32'h8);
      drain();

      rand_bytes(9, b);
      do_load(b, 1'b0, 0, 1'b1);
      @(negedge clk);
      chk("post_abort_hold", 64'(bus.cpu_hold_o), 64'd0);
      fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
      drain();
      rand_fetch(50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end
endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction-memory responder for the CPU fetch port. Each cycle it takes the byte address the core drives on its ROM address output and returns the 32-bit instruction word one cycle later. It also has a byte-serial program-load port that packs bytes into words and writes them into the array. While a load is in progress, the core is held off.

## Interface

Parameters:
- ADDR_W, 10: word-address width; array depth = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_rom_i  in  32  fetch byte address from CPU.
- data_rom_o  out  32  instruction word, registered.
- rom_valid_o  out  1  data_rom_o is a valid fetch response.
- addr_err_o  out  1  previous fetch was misaligned or out of range.
- load_en_i  in  1  level; high requests and holds load mode.
- load_byte_valid_i  in  1  load_byte_i is valid this cycle.
- load_byte_i  in  8  program byte, little-endian stream.
- cpu_hold_o  out  1  CPU must stall/stay in reset while high.
- load_done_o  out  1  one-cycle pulse at end of load.
- load_overflow_o  out  1  sticky; bytes were dropped because the array was full.
- load_count_o  out  ADDR_W+1  words written by the current or last load.

## Operation

- States:
  - RUN: reset state; fetches are served.
  - LOAD: bytes are accepted.
  - FLUSH: one cycle; commits any partial word, then returns to RUN.
- RUN -> LOAD when load_en_i = 1.
  - On entry: clear the byte counter, the word pointer, load_count_o and load_overflow_o.
- In LOAD, each cycle with load_byte_valid_i = 1 places byte k (k = 0..3) into the assembler at bits [8k+7:8k].
  - On the 4th byte, write the word to mem[wptr], then increment wptr and load_count_o.
- When wptr = 2**ADDR_W, further bytes are discarded and load_overflow_o is set.
- LOAD -> FLUSH when load_en_i = 0.
  - In FLUSH, if 1-3 bytes are pending, write them with the upper bytes zero-filled and increment load_count_o.
  - FLUSH -> RUN on the next cycle, with load_done_o = 1 for that FLUSH cycle.
- Simultaneous events:
  - Byte valid in the same cycle load_en_i falls: the byte is accepted.
  - If that byte completes a word, the word is written in that cycle and FLUSH writes nothing.
- Bytes presented in RUN are ignored.
- Fetch decode:
  - Word index = addr_rom_i[ADDR_W+1:2].
  - Misaligned: addr_rom_i[1:0] != 0.
  - Out of range: addr_rom_i[31:ADDR_W+2] != 0.
  - On a misaligned or out-of-range fetch: data_rom_o = 0, addr_err_o = 1.
- cpu_hold_o = 1 in LOAD and FLUSH, 0 in RUN.
- Array contents are not reset.
  - After reset or a mid-load reset, words already written remain.
  - Unwritten words read as undefined.

## Timing

- Reset values:
  - state = RUN.
  - data_rom_o = 0, rom_valid_o = 0, addr_err_o = 0.
  - cpu_hold_o = 0, load_done_o = 0, load_overflow_o = 0, load_count_o = 0.
  - Byte counter and wptr = 0.
- Fetch latency is 1 cycle: address sampled at edge N gives data_rom_o/addr_err_o valid after edge N, with rom_valid_o = 1.
  - This allows back-to-back fetches every cycle.
- In LOAD/FLUSH, data_rom_o = 0 and rom_valid_o = 0.
- The first fetch response after load is valid 1 cycle after state returns to RUN.
- cpu_hold_o is registered:
  - Rises the cycle after load_en_i is first sampled high.
  - Falls the cycle after FLUSH.
- Array write occurs at the edge sampling the 4th byte, or at the FLUSH edge.
  - A read of the same word is never concurrent, because the CPU is held.
- load_count_o holds its final value until the next LOAD entry.
- Reset asserted mid-load returns to RUN immediately (asynchronous).
  - No partial-word commit and no load_done_o pulse.

## Test plan

- Load 8 bytes 0x13,0x00,0x00,0x00,0xB7,0x10,0x00,0x00, then drop load_en_i -> mem[0] = 0x00000013, mem[1] = 0x000010B7, load_count_o = 2, one load_done_o pulse, cpu_hold_o high throughout.
- Load 6 bytes 0x01..0x06 -> mem[1] = 0x00000605 (zero-padded in FLUSH), load_count_o = 2.
- After the load, fetch addresses 0x0, 0x4, 0x0 on consecutive cycles -> data_rom_o = 0x00000013, 0x000010B7, 0x00000013, each 1 cycle later, rom_valid_o = 1.
- Fetch 0x2, and fetch 1<<(ADDR_W+2) -> data_rom_o = 0, addr_err_o = 1 on the following cycle.
- 4th byte valid in the same cycle load_en_i falls -> word written once, no extra FLUSH write, load_count_o incremented by exactly 1.
- Stream (2**ADDR_W)*4 + 4 bytes -> array full, load_overflow_o = 1, load_count_o = 2**ADDR_W.
- Reset pulsed mid-word during a load -> all outputs at reset values, state RUN, earlier complete words retained.
